alu64bit_arbiter: RTL



---
 rtl/alu64bit_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu64bit_arbiter.sv
// alu64bit_arbiter: round-robin arbiter and sequencer that lets two clients
// share one combinational alu64bit. Each operation walks IDLE -> EXEC -> RESP:
// operands are registered on acceptance, the ALU result is captured one cycle
// later, and the captured result is held until the granted client takes it.
module alu64bit_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_cin,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             grant_id_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic             alu_cin_reg;
  logic [1:0]       alu_op_reg;
  logic [WIDTH-1:0] rsp_s_reg;
  logic             rsp_cout_reg;
  logic [1:0]       rsp_valid_reg;
  logic             busy_reg;

  logic             sel;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;
  logic [1:0]       sel_op;

  // Arbitration: a lone requester wins outright; on contention the one that
  // was not served last wins.
  always_comb begin
    sel = 1'b0;
    case (req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant_reg;
      default: sel = 1'b0;
    endcase
  end

  // Ready only in IDLE, only to the selected requester, and only with its
  // valid; held low while reset is asserted so nothing is accepted in reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      localparam logic IDX = 1'(gi);
      assign req_ready[gi] = ~rst & (state_reg == IDLE) & req_valid[gi] & (sel == IDX);
    end
  endgenerate

  assign accept   = |req_ready;
  assign rsp_fire = (state_reg == RESP) & rsp_ready[grant_id_reg];

  // Payload of the selected requester; operands pass through untouched.
  always_comb begin
    sel_a   = sel ? req_a1  : req_a0;
    sel_b   = sel ? req_b1  : req_b0;
    sel_op  = sel ? req_op1 : req_op0;
    sel_cin = req_cin[sel];
  end

  // Next-state logic for the three-phase operation sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand capture, result capture, response flags and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_cin_reg    <= 1'b0;
      alu_op_reg     <= 2'b00;
      rsp_s_reg      <= '0;
      rsp_cout_reg   <= 1'b0;
      rsp_valid_reg  <= 2'b00;
      busy_reg       <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      if (state_reg == IDLE && accept) begin
        alu_a_reg    <= sel_a;
        alu_b_reg    <= sel_b;
        alu_cin_reg  <= sel_cin;
        alu_op_reg   <= sel_op;
        grant_id_reg <= sel;
      end
      if (state_reg == EXEC) begin
        rsp_s_reg     <= alu_s;
        rsp_cout_reg  <= alu_cout;
        rsp_valid_reg <= grant_id_reg ? 2'b10 : 2'b01;
      end
      if (rsp_fire) begin
        rsp_valid_reg  <= 2'b00;
        last_grant_reg <= grant_id_reg;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_cin   = alu_cin_reg;
  assign alu_op    = alu_op_reg;
  assign rsp_s     = rsp_s_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = busy_reg;
  assign grant_id  = grant_id_reg;

endmodule
